// File: rtl/axi_read_arbiter.sv
// Burst-locked arbiter sharing one AXI4 read master port between N_MASTERS requesters.
// Define AXI_RD_ARB_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module axi_read_arbiter #(
    parameter int N_MASTERS  = 2,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ID_W   = 1,
    localparam int GRANT_W   = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [N_MASTERS-1:0]            s_arvalid,
    input  logic [N_MASTERS*AXI_ADDR_W-1:0] s_araddr,
    input  logic [N_MASTERS*AXI_LEN_W-1:0]  s_arlen,
    input  logic [N_MASTERS*3-1:0]          s_arsize,
    input  logic [N_MASTERS*2-1:0]          s_arburst,
    output logic [N_MASTERS-1:0]            s_arready,
    output logic [N_MASTERS-1:0]            s_rvalid,
    input  logic [N_MASTERS-1:0]            s_rready,
    output logic [AXI_DATA_W-1:0]           s_rdata,
    output logic [1:0]                      s_rresp,
    output logic                            s_rlast,
    output logic [AXI_ID_W-1:0]             m_axi_arid,
    output logic [AXI_ADDR_W-1:0]           m_axi_araddr,
    output logic [AXI_LEN_W-1:0]            m_axi_arlen,
    output logic [2:0]                      m_axi_arsize,
    output logic [1:0]                      m_axi_arburst,
    output logic                            m_axi_arlock,
    output logic [3:0]                      m_axi_arcache,
    output logic [2:0]                      m_axi_arprot,
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    input  logic                            m_axi_rvalid,
    input  logic [AXI_DATA_W-1:0]           m_axi_rdata,
    input  logic [1:0]                      m_axi_rresp,
    input  logic                            m_axi_rlast,
    output logic                            m_axi_rready,
    output logic                            busy,
    output logic [GRANT_W-1:0]              grant
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0]         r_state;
    logic [GRANT_W-1:0] r_grant;
    logic [GRANT_W-1:0] w_winner;
    logic               w_found;
    logic               w_last_hs;

`ifdef AXI_RD_ARB_RR_EN
    logic [GRANT_W-1:0] r_ptr;

    // Requesters at or above the pointer are searched first, then the wrap-around part.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (!w_found && s_arvalid[i] && (i >= int'(r_ptr))) begin
                w_found  = 1'b1;
                w_winner = GRANT_W'(i);
            end
        end
        for (int i = 0; i < N_MASTERS; i++) begin
            if (!w_found && s_arvalid[i]) begin
                w_found  = 1'b1;
                w_winner = GRANT_W'(i);
            end
        end
    end
`else
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (!w_found && s_arvalid[i]) begin
                w_found  = 1'b1;
                w_winner = GRANT_W'(i);
            end
        end
    end
`endif

    always_comb begin
        m_axi_araddr  = '0;
        m_axi_arlen   = '0;
        m_axi_arsize  = '0;
        m_axi_arburst = '0;
        s_arready     = '0;
        s_rvalid      = '0;
        m_axi_rready  = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (r_grant == GRANT_W'(i)) begin
                m_axi_araddr  = s_araddr[i*AXI_ADDR_W +: AXI_ADDR_W];
                m_axi_arlen   = s_arlen[i*AXI_LEN_W +: AXI_LEN_W];
                m_axi_arsize  = s_arsize[i*3 +: 3];
                m_axi_arburst = s_arburst[i*2 +: 2];
                s_arready[i]  = (r_state == ST_ADDR) && m_axi_arready;
                s_rvalid[i]   = (r_state == ST_DATA) && m_axi_rvalid;
                m_axi_rready  = (r_state == ST_DATA) && s_rready[i];
            end
        end
    end

    assign m_axi_arvalid = (r_state == ST_ADDR);
    assign w_last_hs     = m_axi_rvalid && m_axi_rready && m_axi_rlast;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
`ifdef AXI_RD_ARB_RR_EN
            r_ptr   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_winner;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (m_axi_arready) r_state <= ST_DATA;
                end
                ST_DATA: begin
                    if (w_last_hs) begin
                        r_state <= ST_IDLE;
`ifdef AXI_RD_ARB_RR_EN
                        r_ptr   <= (r_grant == GRANT_W'(N_MASTERS - 1)) ? '0
                                                                       : r_grant + GRANT_W'(1);
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_rdata       = m_axi_rdata;
    assign s_rresp       = m_axi_rresp;
    assign s_rlast       = m_axi_rlast;
    assign m_axi_arid    = '0;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign busy          = (r_state != ST_IDLE);
    assign grant         = r_grant;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed and randomized bench for axi_read_arbiter against a rule-level arbitration model.
module tb_axi_read_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int IW = 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [N-1:0]     s_arvalid;
    logic [N*AW-1:0]  s_araddr;
    logic [N*LW-1:0]  s_arlen;
    logic [N*3-1:0]   s_arsize;
    logic [N*2-1:0]   s_arburst;
    logic [N-1:0]     s_arready;
    logic [N-1:0]     s_rvalid;
    logic [N-1:0]     s_rready;
    logic [DW-1:0]    s_rdata;
    logic [1:0]       s_rresp;
    logic             s_rlast;
    logic [IW-1:0]    m_axi_arid;
    logic [AW-1:0]    m_axi_araddr;
    logic [LW-1:0]    m_axi_arlen;
    logic [2:0]       m_axi_arsize;
    logic [1:0]       m_axi_arburst;
    logic             m_axi_arlock;
    logic [3:0]       m_axi_arcache;
    logic [2:0]       m_axi_arprot;
    logic             m_axi_arvalid;
    logic             m_axi_arready;
    logic             m_axi_rvalid;
    logic [DW-1:0]    m_axi_rdata;
    logic [1:0]       m_axi_rresp;
    logic             m_axi_rlast;
    logic             m_axi_rready;
    logic             busy;
    logic [0:0]       grant;

    int n_assert = 0;
    int n_fail   = 0;
    int model_ptr = 0;

    logic [AW-1:0] req_addr [N];
    logic [LW-1:0] req_len  [N];
    logic [2:0]    req_size [N];
    logic [1:0]    req_burst[N];

    axi_read_arbiter #(
        .N_MASTERS (N),
        .AXI_ADDR_W(AW),
        .AXI_DATA_W(DW),
        .AXI_LEN_W (LW),
        .AXI_ID_W  (IW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_arvalid    (s_arvalid),
        .s_araddr     (s_araddr),
        .s_arlen      (s_arlen),
        .s_arsize     (s_arsize),
        .s_arburst    (s_arburst),
        .s_arready    (s_arready),
        .s_rvalid     (s_rvalid),
        .s_rready     (s_rready),
        .s_rdata      (s_rdata),
        .s_rresp      (s_rresp),
        .s_rlast      (s_rlast),
        .m_axi_arid   (m_axi_arid),
        .m_axi_araddr (m_axi_araddr),
        .m_axi_arlen  (m_axi_arlen),
        .m_axi_arsize (m_axi_arsize),
        .m_axi_arburst(m_axi_arburst),
        .m_axi_arlock (m_axi_arlock),
        .m_axi_arcache(m_axi_arcache),
        .m_axi_arprot (m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rdata  (m_axi_rdata),
        .m_axi_rresp  (m_axi_rresp),
        .m_axi_rlast  (m_axi_rlast),
        .m_axi_rready (m_axi_rready),
        .busy         (busy),
        .grant        (grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Arbitration rule: round-robin from the pointer, or lowest index in fixed mode.
    function automatic int pick(input logic [N-1:0] mask, input int ptr);
`ifdef AXI_RD_ARB_RR_EN
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (mask[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
        req_addr[i]  = a;
        req_len[i]   = l;
        req_size[i]  = 3'($urandom_range(0, 2));
        req_burst[i] = 2'($urandom_range(0, 2));
        s_araddr[i*AW +: AW] = a;
        s_arlen[i*LW +: LW]  = l;
        s_arsize[i*3 +: 3]   = req_size[i];
        s_arburst[i*2 +: 2]  = req_burst[i];
    endtask

    // Called at a negedge in IDLE with s_arvalid already driven; returns at the next IDLE negedge.
    task automatic do_burst(input int m, input int ar_delay, input int stall_beat,
                            input int stall_cycles, input int err_beat,
                            input logic [N-1:0] late_mask, input bit rnd, input int rst_beat);
        int            len;
        int            b;
        int            stalls;
        int            hs_cnt;
        bit            pending;
        bit            gap;
        logic          rdy;
        logic [DW-1:0] cur_data;
        logic [1:0]    cur_resp;
        len     = int'(req_len[m]);
        b       = 0;
        stalls  = 0;
        hs_cnt  = 0;
        pending = 1'b0;
        cur_data = '0;
        cur_resp = '0;
        #1;
        chk("idle_arvalid", m_axi_arvalid, 0);
        chk("idle_busy", busy, 0);
        for (int k = 0; k <= ar_delay; k++) begin
            @(negedge clk);
            m_axi_arready = (k == ar_delay);
            #1;
            chk("ar_valid", m_axi_arvalid, 1);
            chk("ar_grant", grant, m);
            chk("ar_busy", busy, 1);
            chk("ar_addr", m_axi_araddr, req_addr[m]);
            chk("ar_len", m_axi_arlen, req_len[m]);
            chk("ar_size", m_axi_arsize, req_size[m]);
            chk("ar_burst", m_axi_arburst, req_burst[m]);
            chk("ar_ready_route", s_arready, (k == ar_delay) ? (1 << m) : 0);
        end
        @(negedge clk);
        m_axi_arready = 1'b0;
        s_arvalid[m]  = 1'b0;
        s_arvalid     = s_arvalid | late_mask;
        while (b <= len) begin
            gap = rnd && !pending && ($urandom_range(0, 3) == 0);
            if (!pending) begin
                cur_data = $urandom;
                cur_resp = rnd ? 2'($urandom_range(0, 3)) : ((b == err_beat) ? 2'b10 : 2'b00);
            end
            if (rnd) rdy = ($urandom_range(0, 3) != 0);
            else     rdy = !((b == stall_beat) && (stalls < stall_cycles));
            m_axi_rvalid = !gap;
            m_axi_rdata  = cur_data;
            m_axi_rresp  = cur_resp;
            m_axi_rlast  = (b == len);
            s_rready     = '1;
            s_rready[m]  = rdy;
            #1;
            chk("r_valid_route", s_rvalid, gap ? 0 : (1 << m));
            chk("r_ready_pass", m_axi_rready, rdy);
            chk("r_no_arready", s_arready, 0);
            chk("r_no_arvalid", m_axi_arvalid, 0);
            if (!gap) begin
                chk("r_data", s_rdata, cur_data);
                chk("r_resp", s_rresp, cur_resp);
                chk("r_last", s_rlast, (b == len));
                if (m_axi_rvalid && m_axi_rready) hs_cnt++;
                if (rdy) begin
                    b++;
                    pending = 1'b0;
                end else begin
                    stalls++;
                    pending = 1'b1;
                end
            end
            if (b == rst_beat) begin
                reset_n = 1'b0;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_grant", grant, 0);
                chk("rst_svalid", s_rvalid, 0);
                chk("rst_rready", m_axi_rready, 0);
                chk("rst_arvalid", m_axi_arvalid, 0);
                chk("rst_arready", s_arready, 0);
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
                s_arvalid    = '0;
                @(negedge clk);
                reset_n   = 1'b1;
                model_ptr = 0;
                return;
            end
            @(negedge clk);
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        #1;
        chk("beat_count", hs_cnt, len + 1);
        chk("end_busy", busy, 0);
        chk("end_svalid", s_rvalid, 0);
        model_ptr = (m + 1) % N;
    endtask

    initial begin
        int exp_t2[4];
        int m;
        logic [N-1:0] mask;
`ifdef AXI_RD_ARB_RR_EN
        exp_t2 = '{0, 1, 0, 1};
`else
        exp_t2 = '{0, 0, 0, 0};
`endif
        reset_n       = 1'b0;
        s_arvalid     = '0;
        s_rready      = '0;
        s_araddr      = '0;
        s_arlen       = '0;
        s_arsize      = '0;
        s_arburst     = '0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = '0;
        m_axi_rlast   = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 32'h0, 8'd0);
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_grant", grant, 0);
        chk("reset_arvalid", m_axi_arvalid, 0);
        chk("reset_rready", m_axi_rready, 0);
        chk("reset_arready", s_arready, 0);
        chk("reset_svalid", s_rvalid, 0);
        chk("const_arcache", m_axi_arcache, 4'b0011);
        chk("const_arid", m_axi_arid, 0);
        chk("const_arlock", m_axi_arlock, 0);
        chk("const_arprot", m_axi_arprot, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Requester 0 alone, slave AR ready after 2 cycles, 4 beats.
        set_req(0, 32'h100, 8'd3);
        s_arvalid = 2'b01;
        do_burst(0, 2, -1, 0, -1, '0, 1'b0, -1);

        // Simultaneous requests, four bursts.
        for (int t = 0; t < 4; t++) begin
            set_req(0, 32'h1000 + 32'(t * 64), 8'd1);
            set_req(1, 32'h2000 + 32'(t * 64), 8'd2);
            s_arvalid = 2'b11;
            do_burst(exp_t2[t], 0, -1, 0, -1, '0, 1'b0, -1);
        end
        s_arvalid = '0;
        @(negedge clk);

        // Requester 1 arrives during requester 0's data phase.
        set_req(0, 32'h3000, 8'd3);
        set_req(1, 32'h4000, 8'd1);
        s_arvalid = 2'b01;
        do_burst(0, 1, -1, 0, -1, 2'b10, 1'b0, -1);
        chk("late_pick", pick(s_arvalid, model_ptr), 1);
        do_burst(1, 0, -1, 0, -1, '0, 1'b0, -1);

        // Three-cycle rready stall mid-burst.
        set_req(0, 32'h5000, 8'd3);
        s_arvalid = 2'b01;
        do_burst(0, 0, 1, 3, -1, '0, 1'b0, -1);

        // SLVERR on the second of four beats.
        set_req(1, 32'h6000, 8'd3);
        s_arvalid = 2'b10;
        do_burst(1, 1, -1, 0, 1, '0, 1'b0, -1);

        // Reset pulse in the data phase, then a fresh request.
        set_req(1, 32'h7000, 8'd5);
        s_arvalid = 2'b10;
        do_burst(1, 0, -1, 0, -1, '0, 1'b0, 2);
        set_req(0, 32'h8000, 8'd2);
        s_arvalid = 2'b01;
        do_burst(0, 0, -1, 0, -1, '0, 1'b0, -1);

        for (int t = 0; t < 24; t++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) set_req(i, $urandom, LW'($urandom_range(0, 7)));
            s_arvalid = mask;
            m = pick(mask, model_ptr);
            do_burst(m, $urandom_range(0, 3), -1, 0, -1, '0, 1'b1, -1);
            s_arvalid = '0;
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
